srl_tap_ctrl: RTL and testbench

SRL_TAP_CTRL -- requirements
Module: srl_tap_ctrl

---
 rtl/srl_tap_ctrl.sv | 110 +++++++++++
 tb/tb_srl_tap_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srl_tap_ctrl.sv
// Tap controller for an SRL16E video delay line: accepts tap-code requests,
// applies them only during blanking, and flushes the line before flagging valid data.
module srl_tap_ctrl #(
  parameter int MAX_TAPS     = 15,
  parameter int SETTLE_EXTRA = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_taps,
  output logic       req_ready,
  input  logic       de,
  input  logic       abort,
  output logic [3:0] taps_o,
  output logic       out_valid,
  output logic       busy,
  output logic       err_range
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BLANK,
    SETTLE
  } state_e;

  localparam logic [3:0] MaxTapsC  = 4'(MAX_TAPS);
  localparam logic [4:0] MaxTapsW  = 5'(MAX_TAPS);
  localparam logic [4:0] ExtraC    = 5'(SETTLE_EXTRA);
  localparam logic [4:0] ResetCntC = 5'(MAX_TAPS + SETTLE_EXTRA);

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] taps_q, taps_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic       overRange;
  logic [3:0] clamped;

  // Compare in 5 bits so the check stays meaningful when MAX_TAPS is 15.
  assign overRange = {1'b0, req_taps} > MaxTapsW;
  assign clamped   = overRange ? MaxTapsC : req_taps;

  // Reset lands in SETTLE so stale SRL contents are flushed before out_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SETTLE;
      pending_q <= 4'd0;
      cnt_q     <= ResetCntC;
      taps_q    <= MaxTapsC;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      taps_q    <= taps_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    taps_d    = taps_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          err_d = overRange;
          if (clamped != taps_q) begin
            pending_d = clamped;
            state_d   = WAIT_BLANK;
          end
        end
      end
      WAIT_BLANK: begin
        // Abort has priority over a blanking edge in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (!de) begin
          taps_d  = pending_q;
          valid_d = 1'b0;
          cnt_d   = {1'b0, pending_q} + ExtraC;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 5'd0) begin
          state_d = IDLE;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign taps_o    = taps_q;
  assign out_valid = valid_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_srl_tap_ctrl.sv
// Scoreboard bench for srl_tap_ctrl: a stimulus process predicts each tap change,
// a negedge monitor checks taps, flush length and blanking-only updates.
module tb_srl_tap_ctrl;

  localparam int MaxTaps = 15;
  localparam int Extra   = 2;

  typedef struct {
    int taps;
    int cycles;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       reqValid;
  logic [3:0] reqTaps;
  logic       reqReady;
  logic       de;
  logic       abort;
  logic [3:0] tapsOut;
  logic       outValid;
  logic       busy;
  logic       errRange;

  logic       rst7N;
  logic       reqValid7;
  logic [3:0] reqTaps7;
  logic       reqReady7;
  logic       de7;
  logic       abort7;
  logic [3:0] tapsOut7;
  logic       outValid7;
  logic       busy7;
  logic       errRange7;

  int   checks   = 0;
  int   failures = 0;
  exp_t sbQ[$];
  int   curTaps;

  srl_tap_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (reqValid),
    .req_taps  (reqTaps),
    .req_ready (reqReady),
    .de        (de),
    .abort     (abort),
    .taps_o    (tapsOut),
    .out_valid (outValid),
    .busy      (busy),
    .err_range (errRange)
  );

  srl_tap_ctrl #(.MAX_TAPS(7), .SETTLE_EXTRA(2)) dut7 (
    .clk       (clk),
    .rst_n     (rst7N),
    .req_valid (reqValid7),
    .req_taps  (reqTaps7),
    .req_ready (reqReady7),
    .de        (de7),
    .abort     (abort7),
    .taps_o    (tapsOut7),
    .out_valid (outValid7),
    .busy      (busy7),
    .err_range (errRange7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: counts out_valid-low cycles and pops one expectation per rising out_valid.
  int   lowCount = 0;
  logic prevOv   = 1'b0;
  logic [3:0] prevTaps = 4'd0;
  logic deAtEdge = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      lowCount = 0;
      prevOv   = 1'b0;
    end else begin
      if (!outValid) lowCount++;
      if (outValid && !prevOv) begin
        if (sbQ.size() == 0) begin
          checkOutput("sbUnexpectedValid", 1, 0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("sbTaps", int'(tapsOut), e.taps);
          checkOutput("sbSettleCycles", lowCount, e.cycles);
        end
        lowCount = 0;
      end
      if (deAtEdge && (tapsOut != prevTaps))
        checkOutput("tapsChangedWithDe", int'(tapsOut), int'(prevTaps));
      checkOutput("errRangeMain", int'(errRange), 0);
      prevOv = outValid;
    end
    prevTaps = tapsOut;
    deAtEdge = de;
  end

  task automatic waitReady();
    int n;
    n = 0;
    @(negedge clk);
    while (!reqReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady) checkOutput("readyTimeout", 0, 1);
  endtask

  // Caller has seen req_ready at a negedge; the accept edge follows.
  task automatic applyStimulus(input int v, input int hold, input bit doAbort, input bit abortDe);
    int c;
    @(posedge clk); #1;
    reqValid = 1'b1;
    reqTaps  = 4'(v);
    de       = 1'b1;
    abort    = 1'($urandom_range(0, 1));
    c = (v > MaxTaps) ? MaxTaps : v;
    @(posedge clk); #1;
    reqValid = 1'b0;
    abort    = 1'b0;
    if (c == curTaps) begin
      @(negedge clk);
      checkOutput("noopBusy", int'(busy), 0);
      checkOutput("noopReady", int'(reqReady), 1);
      checkOutput("noopValid", int'(outValid), 1);
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (doAbort) begin
      abort = 1'b1;
      de    = abortDe;
    end else begin
      de    = 1'b0;
      abort = 1'b0;
      sbQ.push_back('{taps: c, cycles: c + Extra + 1});
      curTaps = c;
    end
    @(posedge clk); #1;
    abort = 1'b0;
    de    = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (doAbort) begin
      checkOutput("abortBusy", int'(busy), 0);
      checkOutput("abortTaps", int'(tapsOut), curTaps);
      checkOutput("abortValid", int'(outValid), 1);
    end else begin
      checkOutput("applyTaps", int'(tapsOut), c);
      checkOutput("applyValidLow", int'(outValid), 0);
    end
  endtask

  task automatic releaseReset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sbQ.push_back('{taps: MaxTaps, cycles: MaxTaps + Extra + 1});
    curTaps = MaxTaps;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Taps"}, int'(tapsOut), MaxTaps);
    checkOutput({tag, "Valid"}, int'(outValid), 0);
    checkOutput({tag, "Err"}, int'(errRange), 0);
    checkOutput({tag, "Ready"}, int'(reqReady), 0);
    checkOutput({tag, "Busy"}, int'(busy), 1);
  endtask

  task automatic waitReady7(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!reqReady7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady7) checkOutput({tag, "Timeout"}, 0, 1);
  endtask

  task automatic request7(input int v);
    @(posedge clk); #1;
    reqValid7 = 1'b1;
    reqTaps7  = 4'(v);
    @(posedge clk); #1;
    reqValid7 = 1'b0;
  endtask

  initial begin
    int v, hold, n;
    bit ab, abDe;
    rst_n = 1'b0; reqValid = 1'b0; reqTaps = 4'd0; de = 1'b1; abort = 1'b0;
    rst7N = 1'b0; reqValid7 = 1'b0; reqTaps7 = 4'd0; de7 = 1'b0; abort7 = 1'b0;
    curTaps = MaxTaps;
    repeat (3) @(posedge clk);
    #2;
    checkResetValues("reset");

    releaseReset();
    waitReady();
    checkOutput("postResetTaps", int'(tapsOut), 15);
    checkOutput("postResetValid", int'(outValid), 1);
    checkOutput("postResetBusy", int'(busy), 0);

    applyStimulus(4, 10, 1'b0, 1'b0);
    waitReady();
    applyStimulus(4, 0, 1'b0, 1'b0);
    waitReady();
    applyStimulus(9, 3, 1'b1, 1'b0);
    waitReady();
    applyStimulus(0, 1, 1'b0, 1'b0);
    waitReady();

    // Reset in the middle of a settle must discard the in-flight change.
    applyStimulus(12, 2, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues("midReset");
    sbQ.delete();
    de = 1'b1;
    repeat (2) @(posedge clk);
    releaseReset();
    waitReady();
    checkOutput("midResetTaps", int'(tapsOut), 15);

    for (int i = 0; i < 25; i++) begin
      v    = $urandom_range(0, 15);
      hold = $urandom_range(0, 6);
      ab   = ($urandom_range(0, 3) == 0);
      abDe = 1'($urandom_range(0, 1));
      applyStimulus(v, hold, ab, abDe);
      waitReady();
    end

    n = 0;
    while (sbQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sbDrain", sbQ.size(), 0);

    // Clamping instance, MAX_TAPS=7.
    @(posedge clk); #1;
    rst7N = 1'b1;
    waitReady7("r7Reset");
    checkOutput("r7ResetTaps", int'(tapsOut7), 7);
    checkOutput("r7ResetValid", int'(outValid7), 1);
    request7(3);
    @(negedge clk);
    checkOutput("r7NoErr", int'(errRange7), 0);
    waitReady7("r7Apply3");
    checkOutput("r7Taps3", int'(tapsOut7), 3);
    request7(9);
    @(negedge clk);
    checkOutput("r7ErrPulse", int'(errRange7), 1);
    @(negedge clk);
    checkOutput("r7ErrCleared", int'(errRange7), 0);
    waitReady7("r7Apply9");
    checkOutput("r7TapsClamped", int'(tapsOut7), 7);
    request7(12);
    @(negedge clk);
    checkOutput("r7ErrNoop", int'(errRange7), 1);
    checkOutput("r7BusyNoop", int'(busy7), 0);
    @(negedge clk);
    checkOutput("r7ErrNoopCleared", int'(errRange7), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
